// File: rtl/motor_pkg.sv
// Shared types and widths for the motor segment sequencer and its FIFO.
// Positions are signed two's complement; dividers and dwell counts are unsigned.
package motor_pkg;

    localparam int PW = 19;
    localparam int DW = 13;
    localparam int TW = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_MOVE   = 3'd3,
        S_DWELL  = 3'd4,
        S_ABORT  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic signed [PW-1:0] pos;
        logic        [DW-1:0] div;
        logic        [TW-1:0] dwell;
    } seg_t;

    // A move is finished only once the controller reports the target and has stopped.
    function automatic logic seg_arrived(
        input logic signed [PW-1:0] target,
        input logic signed [PW-1:0] current,
        input logic                 active
    );
        return (target == current) && !active;
    endfunction

endpackage

// File: rtl/motor_seg_sequencer_seg_fifo.sv
// Synchronous show-ahead FIFO of move segments: the head entry is readable
// in the same cycle it is popped. Flush empties it in one cycle.
module seg_fifo
    import motor_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          push,
    input  seg_t          wr_data,
    input  logic          pop,
    input  logic          flush,
    output seg_t          rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    seg_t          r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign full    = (r_level == LW'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: the storage array carries no reset; the level counter alone decides which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/motor_seg_sequencer.sv
// Queues move segments and issues them one at a time to a step/dir controller,
// waiting for arrival plus a dwell before advancing; supports abort and position zeroing.
module motor_seg_sequencer
    import motor_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int SETTLE = 2,
    localparam int LW     = $clog2(DEPTH) + 1,
    localparam int SW     = $clog2(SETTLE) + 1,
    localparam int CW     = (TW > SW) ? TW : SW
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic signed [PW-1:0] cmd_pos,
    input  logic        [DW-1:0] cmd_div,
    input  logic        [TW-1:0] cmd_dwell,
    input  logic                 abort,
    input  logic                 zero_req,
    output logic signed [PW-1:0] mc_new_pos,
    output logic        [DW-1:0] mc_divider,
    output logic                 mc_reset,
    input  logic signed [PW-1:0] mc_cur_pos,
    input  logic                 mc_active,
    output logic                 busy,
    output logic                 seg_done,
    output logic        [LW-1:0] level,
    output logic                 aborted
);

    seq_state_t           r_state;
    seg_t                 r_seg;
    logic signed [PW-1:0] r_new_pos;
    logic        [DW-1:0] r_divider;
    logic        [TW-1:0] r_dwell;
    logic        [CW-1:0] r_cnt;
    logic                 r_mc_reset;

    seg_t    w_cmd;
    seg_t    w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_pop;
    logic    w_abort_take;
    logic    w_cnt_zero;

    assign w_cmd = '{pos: cmd_pos, div: cmd_div, dwell: cmd_dwell};

    // Abort is a no-op when idle with nothing queued, and is ignored while already aborting.
    assign w_abort_take = abort && (r_state != S_ABORT) && !((r_state == S_IDLE) && w_empty);
    assign w_pop        = (r_state == S_IDLE) && !w_empty && !w_abort_take;
    assign w_cnt_zero   = (r_cnt == '0);

    seg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push    (cmd_valid && cmd_ready),
        .wr_data (w_cmd),
        .pop     (w_pop),
        .flush   (w_abort_take),
        .rd_data (w_head),
        .level   (level),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign cmd_ready  = !w_full && !abort;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign seg_done   = (r_state == S_DWELL) && w_cnt_zero && !w_abort_take;
    assign aborted    = (r_state == S_ABORT) && w_cnt_zero && !mc_active;
    assign mc_new_pos = r_new_pos;
    assign mc_divider = r_divider;
    assign mc_reset   = r_mc_reset;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_seg      <= '0;
            r_new_pos  <= '0;
            r_divider  <= '0;
            r_dwell    <= '0;
            r_cnt      <= '0;
            r_mc_reset <= 1'b0;
        end else begin
            r_mc_reset <= 1'b0;
            if (w_abort_take) begin
                // Hold wherever the axis is right now; an in-flight step is walked back.
                r_new_pos <= mc_cur_pos;
                r_cnt     <= CW'(SETTLE - 1);
                r_state   <= S_ABORT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (zero_req && w_empty) begin
                            r_mc_reset <= 1'b1;
                            r_new_pos  <= '0;
                        end else if (!w_empty) begin
                            r_seg   <= w_head;
                            r_state <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_new_pos <= r_seg.pos;
                        r_divider <= r_seg.div;
                        r_dwell   <= r_seg.dwell;
                        r_cnt     <= CW'(SETTLE - 1);
                        r_state   <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // Gives the controller time to raise active before arrival is judged.
                        if (w_cnt_zero) r_state <= S_MOVE;
                        else            r_cnt   <= r_cnt - 1'b1;
                    end
                    S_MOVE: begin
                        if (seg_arrived(r_new_pos, mc_cur_pos, mc_active)) begin
                            r_cnt   <= CW'(r_dwell);
                            r_state <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (w_cnt_zero) r_state <= S_IDLE;
                        else            r_cnt   <= r_cnt - 1'b1;
                    end
                    S_ABORT: begin
                        if (!w_cnt_zero)     r_cnt   <= r_cnt - 1'b1;
                        else if (!mc_active) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_seg_sequencer.sv
// Directed bench for motor_seg_sequencer with a behavioural step/dir controller model
// whose active flag lags its position by one cycle.
module tb_motor_seg_sequencer;
    import motor_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 CLK;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic signed [PW-1:0] cmd_pos;
    logic        [DW-1:0] cmd_div;
    logic        [TW-1:0] cmd_dwell;
    logic                 abort;
    logic                 zero_req;
    logic signed [PW-1:0] mc_new_pos;
    logic        [DW-1:0] mc_divider;
    logic                 mc_reset;
    logic signed [PW-1:0] m_cur;
    logic                 m_active;
    logic                 busy;
    logic                 seg_done;
    logic        [LW-1:0] level;
    logic                 aborted;

    motor_seg_sequencer #(
        .DEPTH  (DEPTH),
        .SETTLE (2)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_pos    (cmd_pos),
        .cmd_div    (cmd_div),
        .cmd_dwell  (cmd_dwell),
        .abort      (abort),
        .zero_req   (zero_req),
        .mc_new_pos (mc_new_pos),
        .mc_divider (mc_divider),
        .mc_reset   (mc_reset),
        .mc_cur_pos (m_cur),
        .mc_active  (m_active),
        .busy       (busy),
        .seg_done   (seg_done),
        .level      (level),
        .aborted    (aborted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Controller model: one step every (divider+1) cycles toward the commanded target.
    logic ctl_rst;
    int   m_cnt;
    int   steps;
    logic m_dir;

    always @(posedge CLK) begin
        if (ctl_rst) begin
            m_cur    <= '0;
            m_active <= 1'b0;
            m_cnt    <= 0;
            steps    <= 0;
            m_dir    <= 1'b0;
        end else begin
            m_active <= (m_cur != mc_new_pos);
            if (mc_reset) begin
                m_cur <= '0;
                m_cnt <= 0;
            end else if (m_cur != mc_new_pos) begin
                if (m_cnt >= int'(mc_divider)) begin
                    m_cnt <= 0;
                    steps <= steps + 1;
                    if (mc_new_pos > m_cur) begin
                        m_cur <= m_cur + PW'(1);
                        m_dir <= 1'b1;
                    end else begin
                        m_cur <= m_cur - PW'(1);
                        m_dir <= 1'b0;
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    int n_done    = 0;
    int n_abort   = 0;
    int n_mreset  = 0;
    int done_log [32];

    always @(negedge CLK) begin
        if (seg_done === 1'b1) begin
            if (n_done < 32) done_log[n_done] = int'(mc_new_pos);
            n_done++;
        end
        if (aborted === 1'b1)  n_abort++;
        if (mc_reset === 1'b1) n_mreset++;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic push(input int pos, input int div, input int dwell, output int waited);
        cmd_valid = 1'b1;
        cmd_pos   = PW'(pos);
        cmd_div   = DW'(div);
        cmd_dwell = TW'(dwell);
        waited    = 0;
        while (!cmd_ready && waited < 2000) begin
            tick(1);
            waited++;
        end
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            tick(1);
            k++;
        end
        tick(1);
        check(tag, 32'(n_done >= target), 1);
    endtask

    initial begin
        int w;
        int k;
        int arr;
        int s0;
        int exp_order [10];

        exp_order = '{30, 5, -3, 0, 7, -7, 2, 2, 12, -1};
        reset     = 1'b1;
        ctl_rst   = 1'b1;
        cmd_valid = 1'b0;
        cmd_pos   = '0;
        cmd_div   = '0;
        cmd_dwell = '0;
        abort     = 1'b0;
        zero_req  = 1'b0;
        tick(3);
        reset   = 1'b0;
        ctl_rst = 1'b0;

        // Reset state
        check("rst_new_pos", mc_new_pos, 0);
        check("rst_divider", mc_divider, 0);
        check("rst_mc_reset", mc_reset, 0);
        check("rst_seg_done", seg_done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_level", level, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);

        // Single segment: 10 steps forward, dwell 5 -> seg_done 6 cycles after arrival
        push(10, 8, 5, w);
        k   = 0;
        arr = -1;
        while (seg_done !== 1'b1 && k < 400) begin
            tick(1);
            k++;
            if (arr < 0 && m_cur == 10 && !m_active) arr = k;
        end
        check("t1_done_seen", seg_done, 1);
        check("t1_latency", k - arr, 6);
        check("t1_steps", steps, 10);
        check("t1_dir", m_dir, 1);
        check("t1_cur", m_cur, 10);
        check("t1_busy_at_done", busy, 1);
        tick(1);
        check("t1_busy_after", busy, 0);
        check("t1_done_pulse", seg_done, 0);

        // Zero-length segment: no steps, seg_done 5 cycles after the accept cycle
        push(10, 4, 0, w);
        check("t2_level", level, 1);
        tick(4);
        check("t2_no_done_yet", seg_done, 0);
        tick(1);
        check("t2_done", seg_done, 1);
        check("t2_steps", steps, 10);
        tick(1);
        check("t2_idle", busy, 0);

        // Leader plus 8 queued segments; the 9th stalls until the first queued pop
        push(30, 3, 0, w);
        push(5, 1, 1, w);
        push(-3, 1, 1, w);
        push(0, 1, 1, w);
        push(7, 1, 1, w);
        push(-7, 1, 1, w);
        push(2, 1, 1, w);
        push(2, 1, 1, w);
        push(12, 1, 1, w);
        check("t3_level_full", level, 8);
        check("t3_ready_low", cmd_ready, 0);
        push(-1, 1, 0, w);
        check("t3_ninth_stalled", 32'(w > 0 && w < 2000), 1);
        wait_done(12, 3000, "t3_all_done");
        for (int i = 0; i < 10; i++)
            check($sformatf("t3_order%0d", i), done_log[2 + i], exp_order[i]);
        check("t3_cur", m_cur, -1);

        // Abort at position 40 while heading to 100 with 3 segments queued
        push(100, 1, 0, w);
        push(1, 1, 0, w);
        push(2, 1, 0, w);
        push(3, 1, 0, w);
        check("t4_level_q", level, 3);
        k = 0;
        while (m_cur != 40 && k < 500) begin
            tick(1);
            k++;
        end
        abort = 1'b1;
        #1;
        check("t4_ready_blocked", cmd_ready, 0);
        tick(1);
        abort = 1'b0;
        check("t4_hold_pos", mc_new_pos, 40);
        check("t4_flushed", level, 0);
        k = 0;
        while (n_abort < 1 && k < 200) begin
            tick(1);
            k++;
        end
        tick(5);
        check("t4_abort_pulses", n_abort, 1);
        check("t4_no_done", n_done, 12);
        check("t4_idle", busy, 0);
        check("t4_cur", m_cur, 40);

        // zero_req in IDLE with empty FIFO at position 25
        push(25, 0, 0, w);
        wait_done(13, 200, "t5_move_done");
        tick(2);
        check("t5_cur_25", m_cur, 25);
        s0       = steps;
        zero_req = 1'b1;
        tick(1);
        zero_req = 1'b0;
        check("t5_mc_reset_hi", mc_reset, 1);
        check("t5_new_pos_0", mc_new_pos, 0);
        tick(1);
        check("t5_mc_reset_lo", mc_reset, 0);
        check("t5_cur_0", m_cur, 0);
        tick(3);
        check("t5_no_steps", steps, s0);
        check("t5_one_pulse", n_mreset, 1);

        // zero_req during MOVE is ignored
        push(6, 3, 0, w);
        k = 0;
        while (m_cur != 3 && k < 200) begin
            tick(1);
            k++;
        end
        zero_req = 1'b1;
        tick(1);
        zero_req = 1'b0;
        check("t5_move_no_reset", mc_reset, 0);
        check("t5_move_target", mc_new_pos, 6);
        wait_done(14, 200, "t5_move6_done");
        check("t5_cur_6", m_cur, 6);
        check("t5_reset_count", n_mreset, 1);

        // Reset during DWELL
        push(9, 0, 20, w);
        k = 0;
        while (!(m_cur == 9 && !m_active) && k < 200) begin
            tick(1);
            k++;
        end
        tick(5);
        check("t6_in_dwell", busy, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_new_pos", mc_new_pos, 0);
        check("t6_divider", mc_divider, 0);
        check("t6_level", level, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", cmd_ready, 1);
        check("t6_seg_done", seg_done, 0);
        tick(30);
        check("t6_no_done", n_done, 14);
        check("t6_returned", m_cur, 0);
        push(4, 2, 1, w);
        wait_done(15, 300, "t6_after_done");
        check("t6_cur_4", m_cur, 4);
        check("t6_log", done_log[14], 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
